// File: rtl/branch_pkg.sv
// Shared types and constants for the LEGv8 branch / PC unit.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_UNCOND = 3'd1,
        BR_CBZ    = 3'd2,
        BR_CBNZ   = 3'd3,
        BR_COND   = 3'd4,
        BR_REG    = 3'd5
    } br_type_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int PC_INCR    = 4;
    localparam int WORD_SHIFT = 2;

    // Flag register layout is {N, Z, C, V}.
    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        return {n, z, c, v};
    endfunction

endpackage

// File: rtl/branch_pc_unit_cond_eval.sv
// B.cond evaluator against registered NZCV flags.
// BRANCH_FULL_COND_EN enables every ARMv8 code; otherwise only EQ/NE/GE/LT.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       result
);

    logic n_s, z_s, c_s, v_s;
    logic gt_s, hi_s;
    logic full_result_s;
    logic supported_s;

    assign n_s  = nzcv[3];
    assign z_s  = nzcv[2];
    assign c_s  = nzcv[1];
    assign v_s  = nzcv[0];
    assign hi_s = c_s & ~z_s;
    assign gt_s = ~z_s & (n_s == v_s);

    // Architectural evaluation of every condition code.
    always_comb begin
        full_result_s = 1'b0;
        case (cond)
            COND_EQ: full_result_s = z_s;
            COND_NE: full_result_s = ~z_s;
            COND_HS: full_result_s = c_s;
            COND_LO: full_result_s = ~c_s;
            COND_MI: full_result_s = n_s;
            COND_PL: full_result_s = ~n_s;
            COND_VS: full_result_s = v_s;
            COND_VC: full_result_s = ~v_s;
            COND_HI: full_result_s = hi_s;
            COND_LS: full_result_s = ~hi_s;
            COND_GE: full_result_s = (n_s == v_s);
            COND_LT: full_result_s = (n_s != v_s);
            COND_GT: full_result_s = gt_s;
            COND_LE: full_result_s = ~gt_s;
            COND_AL: full_result_s = 1'b1;
            COND_NV: full_result_s = 1'b1;
            default: full_result_s = 1'b0;
        endcase
    end

    // Reduced builds mask off every code outside the minimal set.
    always_comb begin
        supported_s = 1'b0;
`ifdef BRANCH_FULL_COND_EN
        supported_s = 1'b1;
`else
        case (cond)
            COND_EQ: supported_s = 1'b1;
            COND_NE: supported_s = 1'b1;
            COND_GE: supported_s = 1'b1;
            COND_LT: supported_s = 1'b1;
            default: supported_s = 1'b0;
        endcase
`endif
    end

    assign result = full_result_s & supported_s;

endmodule

// File: rtl/branch_pc_unit.sv
// Registered PC, NZCV flag register and branch resolution for the LEGv8 core.
// Optional macro BRANCH_FULL_COND_EN widens B.cond support (see cond_eval).
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  br_type_t          br_type,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] br_reg_target,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              set_flags,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              taken,
    output logic [3:0]        flags_q
);

    logic [ADDR_W-1:0] pc_r;
    logic [3:0]        flags_r;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] rel_target_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              cond_taken_s;
    logic              taken_s;

    // B.cond looks only at committed flags, never the in-flight ALU status.
    cond_eval u_cond_eval (
        .cond   (br_cond),
        .nzcv   (flags_r),
        .result (cond_taken_s)
    );

    assign pc_plus4_s   = pc_r + ADDR_W'(PC_INCR);
    assign rel_target_s = pc_r + (br_offset << WORD_SHIFT);

    // Branch decision for the current instruction.
    always_comb begin
        taken_s = 1'b0;
        case (br_type)
            BR_NONE:   taken_s = 1'b0;
            BR_UNCOND: taken_s = 1'b1;
            BR_CBZ:    taken_s = alu_zero;
            BR_CBNZ:   taken_s = ~alu_zero;
            BR_COND:   taken_s = cond_taken_s;
            BR_REG:    taken_s = 1'b1;
            default:   taken_s = 1'b0;
        endcase
    end

    // Next-PC select: register target, PC-relative target, or fall-through.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (taken_s && (br_type == BR_REG)) begin
            next_pc_s = br_reg_target;
        end else if (taken_s) begin
            next_pc_s = rel_target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // PC and flag state; reset wins over a committing instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= {ADDR_W{1'b0}};
            flags_r <= 4'b0000;
        end else if (pc_en) begin
            pc_r <= next_pc_s;
            if (set_flags) begin
                flags_r <= pack_nzcv(alu_neg, alu_zero, alu_carry, alu_ovf);
            end
        end
    end

    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_s;
    assign taken    = taken_s;
    assign flags_q  = flags_r;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: behavioural model plus literal pins.
module tb_branch_pc_unit;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    br_type_t    br_type;
    logic [3:0]  br_cond;
    logic [63:0] br_offset;
    logic [63:0] br_reg_target;
    logic        alu_zero, alu_neg, alu_carry, alu_ovf, set_flags;
    logic [63:0] pc, pc_plus4;
    logic        taken;
    logic [3:0]  flags_q;

    int errors = 0;
    int checks = 0;
    logic check_en = 1'b0;

    logic [63:0] m_pc;
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    branch_pc_unit #(.ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .br_type(br_type),
        .br_cond(br_cond), .br_offset(br_offset), .br_reg_target(br_reg_target),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
        .alu_ovf(alu_ovf), .set_flags(set_flags), .pc(pc), .pc_plus4(pc_plus4),
        .taken(taken), .flags_q(flags_q)
    );

    function automatic bit m_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
`ifdef BRANCH_FULL_COND_EN
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !(c && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return !(!z && (n == v));
            default: return 1'b1;
        endcase
`else
        if (code == 4'h0) return z;
        if (code == 4'h1) return !z;
        if (code == 4'hA) return n == v;
        if (code == 4'hB) return n != v;
        return 1'b0;
`endif
    endfunction

    function automatic bit m_taken();
        case (br_type)
            BR_UNCOND, BR_REG: return 1'b1;
            BR_CBZ:  return alu_zero;
            BR_CBNZ: return !alu_zero;
            BR_COND: return m_cond(br_cond, m_flags);
            default: return 1'b0;
        endcase
    endfunction

    // Model state advances with the clock from the same inputs the DUT sees.
    always @(posedge clk) begin
        if (reset) begin
            m_pc    <= 64'd0;
            m_flags <= 4'd0;
        end else if (pc_en) begin
            if (m_taken() && br_type == BR_REG) m_pc <= br_reg_target;
            else if (m_taken())                 m_pc <= m_pc + br_offset * 64'd4;
            else                                m_pc <= m_pc + 64'd4;
            if (set_flags) m_flags <= {alu_neg, alu_zero, alu_carry, alu_ovf};
        end
    end

    // Every cycle, away from the active edge, compare all outputs to the model.
    always @(negedge clk) begin
        if (check_en) begin
            checks += 4;
            if (pc !== m_pc) begin
                errors++; $display("FAIL pc got=%h exp=%h t=%0t", pc, m_pc, $time);
            end
            if (pc_plus4 !== m_pc + 64'd4) begin
                errors++; $display("FAIL pc_plus4 got=%h exp=%h t=%0t", pc_plus4, m_pc + 64'd4, $time);
            end
            if (taken !== m_taken()) begin
                errors++; $display("FAIL taken got=%b exp=%b t=%0t", taken, m_taken(), $time);
            end
            if (flags_q !== m_flags) begin
                errors++; $display("FAIL flags_q got=%b exp=%b t=%0t", flags_q, m_flags, $time);
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic set_in(input br_type_t t, input logic [3:0] cnd, input logic [63:0] off,
                          input logic [63:0] tgt, input logic z, input logic n,
                          input logic c, input logic v, input logic sf, input logic en);
        br_type = t; br_cond = cnd; br_offset = off; br_reg_target = tgt;
        alu_zero = z; alu_neg = n; alu_carry = c; alu_ovf = v;
        set_flags = sf; pc_en = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit full;
`ifdef BRANCH_FULL_COND_EN
        full = 1'b1;
`else
        full = 1'b0;
`endif
        reset = 1'b1;
        set_in(BR_UNCOND, 4'h0, 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        check_en = 1'b1;
        set_in(BR_NONE, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        lit("reset_pc", pc, 64'd0);
        lit("reset_pc_plus4", pc_plus4, 64'd4);
        lit("reset_flags", {60'd0, flags_q}, 64'd0);
        lit("reset_taken", {63'd0, taken}, 64'd0);

        tick(); lit("seq_pc4", pc, 64'd4);
        tick(); lit("seq_pc8", pc, 64'd8);
        // SUBS at pc=8: N=1, V=0
        set_in(BR_NONE, 4'h0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); lit("subs_pc", pc, 64'd12); lit("subs_flags", {60'd0, flags_q}, 64'h8);
        // B.LT -2 at pc=12
        set_in(BR_COND, 4'hB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; lit("blt_taken", {63'd0, taken}, 64'd1);
        tick(); lit("blt_pc", pc, 64'd4);

        set_in(BR_REG, 4'h0, 64'd0, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(BR_CBZ, 4'h0, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("cbz_taken_pc", pc, 64'h114);
        set_in(BR_REG, 4'h0, 64'd0, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(BR_CBZ, 4'h0, 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("cbz_not_taken_pc", pc, 64'h104);
        set_in(BR_CBNZ, 4'h0, 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("cbnz_taken_pc", pc, 64'h118);

        set_in(BR_REG, 4'h0, 64'd0, 64'h0000_0000_DEAD_BEE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("br_pc", pc, 64'h0000_0000_DEAD_BEE0);
        // Hold with a would-be taken branch and flag write pending
        set_in(BR_UNCOND, 4'h0, 64'd7, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        lit("hold_pc", pc, 64'h0000_0000_DEAD_BEE0);
        lit("hold_flags", {60'd0, flags_q}, 64'h8);

        set_in(BR_REG, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("wrap_pc_plus4", pc_plus4, 64'd0);
        set_in(BR_NONE, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("wrap_pc", pc, 64'd0);
        set_in(BR_UNCOND, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("neg_wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // SUBS giving NZCV=0000, then GT / AL / NE / EQ
        set_in(BR_NONE, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); lit("clear_flags", {60'd0, flags_q}, 64'd0);
        set_in(BR_COND, 4'hC, 64'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; lit("gt_taken", {63'd0, taken}, {63'd0, full});
        tick();
        set_in(BR_COND, 4'hE, 64'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; lit("al_taken", {63'd0, taken}, {63'd0, full});
        tick();
        for (int k = 0; k < 16; k++) begin
            set_in(BR_COND, 4'(k), 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_in(BR_COND, 4'h1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; lit("ne_taken", {63'd0, taken}, 64'd1);
        tick();

        // Illegal flag-setting B.EQ: branch sees old Z=0, flags still update
        set_in(BR_COND, 4'h0, 64'd8, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1; lit("eq_old_flags", {63'd0, taken}, 64'd0);
        tick(); lit("eq_new_flags", {60'd0, flags_q}, 64'h4);
        set_in(BR_COND, 4'h0, 64'd8, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; lit("eq_taken", {63'd0, taken}, 64'd1);
        tick();
        // Non-zero flags across the whole code space
        set_in(BR_NONE, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 16; k++) begin
            set_in(BR_COND, 4'(k), 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end

        set_in(br_type_t'(3'd6), 4'h0, 64'd9, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; lit("undef_type_taken", {63'd0, taken}, 64'd0);
        tick();

        // Reset with a committing UNCOND and flag write
        reset = 1'b1;
        set_in(BR_UNCOND, 4'h0, 64'd9, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); lit("reset_mid_pc", pc, 64'd0); lit("reset_mid_flags", {60'd0, flags_q}, 64'd0);
        reset = 1'b0;
        set_in(BR_NONE, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); lit("post_reset_pc", pc, 64'd4);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
